// File: rtl/sine_freq_meter_if.sv
// -----------------------------------------------------------------------------
// sine_freq_meter_if
//   Bundles the sample stream entering the frequency meter and the measurement
//   results leaving it.
//
//   master : the sample source / result consumer (drives in_valid, sine_wav)
//   slave  : the meter itself (drives the measurement outputs)
//
//   Signals
//     in_valid    sine_wav carries a valid sample this cycle
//     sine_wav    signed two's-complement sample, DATA_WIDTH bits
//     period_out  last measured period, in valid samples
//     step_est    recovered phase step, floor(2^ADDR_WIDTH / period)
//     meas_valid  1-cycle pulse, period_out/step_est just updated
//     busy        divider running
//     overrun     1-cycle pulse, crossing dropped because divider was busy
//     timeout     1-cycle pulse, no crossing within 2^CNT_WIDTH-1 samples
// -----------------------------------------------------------------------------
interface sine_freq_meter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] sine_wav;
    logic [CNT_WIDTH-1:0]         period_out;
    logic [ADDR_WIDTH-1:0]        step_est;
    logic                         meas_valid;
    logic                         busy;
    logic                         overrun;
    logic                         timeout;

    modport master (
        output in_valid,
        output sine_wav,
        input  period_out,
        input  step_est,
        input  meas_valid,
        input  busy,
        input  overrun,
        input  timeout
    );

    modport slave (
        input  in_valid,
        input  sine_wav,
        output period_out,
        output step_est,
        output meas_valid,
        output busy,
        output overrun,
        output timeout
    );
endinterface

// File: rtl/sine_freq_meter.sv
// -----------------------------------------------------------------------------
// sine_freq_meter
//   Receive-side counterpart of sine_gen. Watches a signed sample stream,
//   counts valid samples between rising zero crossings and converts that
//   period back into the phase step that produced it:
//       step_est = floor(2^ADDR_WIDTH / period)
//   The division is a restoring divider producing one quotient bit per clock.
//
//   Ports
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset, released synchronously upstream
//     bus      sine_freq_meter_if.slave
//                in : in_valid, sine_wav
//                out: period_out, step_est, meas_valid, busy, overrun, timeout
//
//   Optional feature
//     SINE_FREQ_METER_HYST_EN : when defined, the "negative" flag behaves as a
//     Schmitt trigger: it sets only when a sample is below -HYST and clears
//     only on a crossing. The HYST parameter exists only in that build.
// -----------------------------------------------------------------------------
module sine_freq_meter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
`ifdef SINE_FREQ_METER_HYST_EN
    ,
    parameter int HYST       = 0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    sine_freq_meter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_e;

    // Divider needs ADDR_WIDTH+1 shift steps; the extra count value 0 is the
    // result-publish cycle.
    localparam int DCW = $clog2(ADDR_WIDTH + 2);
    localparam logic [DCW-1:0]        DivSteps = DCW'(ADDR_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0]  CntMax   = '1;
    localparam logic signed [DATA_WIDTH-1:0] Zero = '0;
`ifdef SINE_FREQ_METER_HYST_EN
    localparam logic signed [DATA_WIDTH-1:0] NegThr = DATA_WIDTH'(-HYST);
`endif

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    // Returns {quotient_bit, new_remainder}. The remainder is always below the
    // divisor, so the subtraction result fits in CNT_WIDTH bits.
    function automatic logic [CNT_WIDTH:0] div_step(
        input logic [CNT_WIDTH-1:0] rem,
        input logic [CNT_WIDTH-1:0] divisor,
        input logic                 dvd_bit
    );
        logic [CNT_WIDTH:0] trial;
        trial = {rem, dvd_bit};
        if (trial >= {1'b0, divisor})
            div_step = {1'b1, trial[CNT_WIDTH-1:0] - divisor};
        else
            div_step = {1'b0, trial[CNT_WIDTH-1:0]};
    endfunction

    state_e                 state_q,   state_d;
    logic                   neg_q,     neg_d;
    logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
    logic [CNT_WIDTH-1:0]   per_q,     per_d;      // period latched for the divider
    logic [CNT_WIDTH-1:0]   rem_q,     rem_d;
    // Quotient is ADDR_WIDTH+1 bits long, but for period >= 2 its top bit is
    // always 0, so only the low ADDR_WIDTH bits are kept: the top bit simply
    // shifts out of the register.
    logic [ADDR_WIDTH-1:0]  quo_q,     quo_d;
    logic [DCW-1:0]         div_cnt_q, div_cnt_d;
    logic [CNT_WIDTH-1:0]   period_q,  period_d;
    logic [ADDR_WIDTH-1:0]  step_q,    step_d;
    logic                   meas_q,    meas_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;

    logic                   sample_neg;
    logic                   xing;
    logic                   tmo;
    logic [CNT_WIDTH:0]     step_res;

    // Signed compare against zero is the sign bit, but uses the full sample.
    assign sample_neg = (bus.sine_wav < Zero);

    // Rising crossing: previous valid sample was negative, this one is not.
    assign xing = bus.in_valid && neg_q && !sample_neg;

    // A crossing on the limit count is a legal period, so it beats timeout.
    assign tmo  = bus.in_valid && !xing && (state_q != IDLE) && (cnt_q == CntMax);

    // The dividend is 2^ADDR_WIDTH: its only 1 bit enters on the first step.
    assign step_res = div_step(rem_q, per_q, div_cnt_q == DivSteps);

    always_comb begin
        state_d   = state_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_cnt_d = div_cnt_q;
        period_d  = period_q;
        step_d    = step_q;
        meas_d    = 1'b0;
        overrun_d = 1'b0;
        timeout_d = 1'b0;

        // Negative-half tracking; invalid cycles leave it untouched.
        if (bus.in_valid) begin
`ifdef SINE_FREQ_METER_HYST_EN
            if (xing)
                neg_d = 1'b0;
            else if (bus.sine_wav < NegThr)
                neg_d = 1'b1;
`else
            neg_d = sample_neg;
`endif
        end

        // Period counter runs regardless of divider activity so that a
        // crossing dropped as an overrun still restarts the count.
        if (xing)
            cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        else if (tmo)
            cnt_d = '0;
        else if (state_q == IDLE)
            cnt_d = '0;
        else if (bus.in_valid)
            cnt_d = cnt_q + 1'b1;

        timeout_d = tmo;

        unique case (state_q)
            IDLE: begin
                // First crossing only arms the measurement.
                if (xing)
                    state_d = MEASURE;
            end

            MEASURE: begin
                if (tmo) begin
                    state_d = IDLE;
                end else if (xing) begin
                    per_d     = cnt_q;
                    rem_d     = '0;
                    quo_d     = '0;
                    div_cnt_d = DivSteps;
                    state_d   = DIVIDE;
                end
            end

            DIVIDE: begin
                if (xing)
                    overrun_d = 1'b1;

                if (tmo) begin
                    // Abort the division; results keep their previous values.
                    state_d = IDLE;
                end else if (div_cnt_q != '0) begin
                    rem_d     = step_res[CNT_WIDTH-1:0];
                    quo_d     = {quo_q[ADDR_WIDTH-2:0], step_res[CNT_WIDTH]};
                    div_cnt_d = div_cnt_q - 1'b1;
                end else begin
                    step_d   = quo_q;
                    period_d = per_q;
                    meas_d   = 1'b1;
                    state_d  = MEASURE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            per_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_cnt_q <= '0;
            period_q  <= '0;
            step_q    <= '0;
            meas_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_cnt_q <= div_cnt_d;
            period_q  <= period_d;
            step_q    <= step_d;
            meas_q    <= meas_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.period_out = period_q;
    assign bus.step_est   = step_q;
    assign bus.meas_valid = meas_q;
    assign bus.busy       = (state_q == DIVIDE);
    assign bus.overrun    = overrun_q;
    assign bus.timeout    = timeout_q;

endmodule
